event_inject: RTL and testbench

EVENT_INJECT -- requirements
Module: event_inject

---
 rtl/event_inject.sv | 127 ++++++++++++
 tb/tb_event_inject.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/event_inject.sv
// event_inject: FIFO-backed scheduler that replays {delay, data} requests as timed event pulses.
// Build option EVENT_INJECT_ACK_EN: hold each event until an evt_ready handshake instead of a 1-cycle pulse.
module event_inject #(
    parameter int DW    = 8,
    parameter int DLYW  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DLYW-1:0]            req_delay,
    input  logic [DW-1:0]              req_data,
    output logic                       evt_valid,
    output logic [DW-1:0]              evt_data,
    input  logic                       evt_ready,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int EW = DLYW + DW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] FIRE  = 2'd2;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic [1:0]      state;
    logic [DLYW-1:0] cnt;
    logic [DW-1:0]   data_p0;
    logic [EW-1:0]   head;
    logic            full;
    logic            push;
    logic            pop;
    logic            fire_done;

    assign full      = (count == PW'(DEPTH));
    assign req_ready = !full;
    assign push      = req_valid && !full && !flush;
    assign pop       = (state == IDLE) && (count != '0) && !flush;
    assign head      = mem[rd_ptr];
    assign pending   = count;
    assign busy      = (count != '0) || (state != IDLE);

`ifdef EVENT_INJECT_ACK_EN
    assign fire_done = evt_ready;
`else
    logic evt_ready_unused;
    assign evt_ready_unused = evt_ready;
    assign fire_done        = 1'b1;
`endif

    // Request storage: payload only, pointers and occupancy live in the control block
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_delay, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            data_p0 <= head[DW-1:0];
        end
    end

    // Control: flush outranks push, pop and fire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            evt_valid <= 1'b0;
            evt_data  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            evt_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        cnt   <= head[EW-1:DW];
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (cnt == '0) begin
                        evt_valid <= 1'b1;
                        evt_data  <= data_p0;
                        state     <= FIRE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIRE: begin
                    if (fire_done) begin
                        evt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_event_inject.sv
// Directed self-checking bench for event_inject: latency, ordering, backpressure, flush and reset.
module tb_event_inject;
    localparam int DW    = 8;
    localparam int DLYW  = 16;
    localparam int DEPTH = 4;

    logic            clk       = 1'b0;
    logic            rst       = 1'b0;
    logic            flush     = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [DLYW-1:0] req_delay = '0;
    logic [DW-1:0]   req_data  = '0;
    logic            evt_valid;
    logic [DW-1:0]   evt_data;
    logic            evt_ready = 1'b1;
    logic [2:0]      pending;
    logic            busy;

    int total  = 0;
    int bad    = 0;
    int edge_n = 0;
    int fire_cyc[$];
    logic [7:0] fire_dat[$];
    int acc0;
    int acc;
    int k;

    event_inject #(.DW(DW), .DLYW(DLYW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_delay(req_delay), .req_data(req_data),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (evt_valid) begin
            fire_cyc.push_back(edge_n);
            fire_dat.push_back(evt_data);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one request, waits (bounded) for ready, returns the acceptance edge
    task automatic push(input logic [15:0] d, input logic [7:0] dat, output int acc_e);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_delay = d;
        req_data  = dat;
        while (!req_ready && w < 100) begin
            step();
            w++;
        end
        chk($sformatf("ready_%0h", dat), 32'(req_ready), 32'd1);
        step();
        acc_e = edge_n;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_evt_valid"}, 32'(evt_valid), 32'd0);
        chk({pfx, "_evt_data"},  32'(evt_data),  32'd0);
        chk({pfx, "_pending"},   32'(pending),   32'd0);
        chk({pfx, "_busy"},      32'(busy),      32'd0);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1;
        chk_reset_outputs("rst0");
        repeat (2) step();
        rst = 1'b1;
        step();

        // Single D=0 event: fires at E0+2 for exactly one cycle
        push(16'd0, 8'hA5, acc);
        req_valid = 1'b0;
        chk("a5_pend_e0", 32'(pending), 32'd1);
        chk("a5_busy_e0", 32'(busy), 32'd1);
        step();
        chk("a5_valid_e1", 32'(evt_valid), 32'd0);
        chk("a5_pend_e1", 32'(pending), 32'd0);
        step();
        chk("a5_valid_e2", 32'(evt_valid), 32'd1);
        chk("a5_data_e2", 32'(evt_data), 32'hA5);
        step();
        chk("a5_valid_e3", 32'(evt_valid), 32'd0);
        chk("a5_busy_e3", 32'(busy), 32'd0);

        // {3,11} then {0,22}: fires at E0+5 and E0+8
        fire_cyc.delete();
        fire_dat.delete();
        push(16'd3, 8'h11, acc0);
        push(16'd0, 8'h22, acc);
        req_valid = 1'b0;
        repeat (10) step();
        chk("two_count", 32'(fire_cyc.size()), 32'd2);
        if (fire_cyc.size() >= 2) begin
            chk("two_t11", 32'(fire_cyc[0] - acc0), 32'd5);
            chk("two_d11", 32'(fire_dat[0]), 32'h11);
            chk("two_t22", 32'(fire_cyc[1] - acc0), 32'd8);
            chk("two_d22", 32'(fire_dat[1]), 32'h22);
        end

        // Five D=10 requests back-to-back, then a sixth that must wait for space
        fire_cyc.delete();
        fire_dat.delete();
        push(16'd10, 8'h40, acc0);
        for (int i = 1; i < 5; i++) begin
            push(16'd10, 8'(8'h40 + i), acc);
        end
        chk("bp_back2back", 32'(acc - acc0), 32'd4);
        chk("bp_pending_full", 32'(pending), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        push(16'd0, 8'h99, acc);
        req_valid = 1'b0;
        k = 0;
        while (fire_cyc.size() < 6 && k < 200) begin
            step();
            k++;
        end
        chk("bp_fire_count", 32'(fire_cyc.size()), 32'd6);
        for (int i = 0; i < 5; i++) begin
            if (i < fire_cyc.size()) begin
                chk($sformatf("bp_t%0d", i), 32'(fire_cyc[i] - acc0), 32'(12 + 13 * i));
                chk($sformatf("bp_d%0d", i), 32'(fire_dat[i]), 32'(8'h40 + i));
            end
        end
        if (fire_cyc.size() >= 6) begin
            chk("bp_t5", 32'(fire_cyc[5] - fire_cyc[4]), 32'd3);
            chk("bp_d5", 32'(fire_dat[5]), 32'h99);
        end
        repeat (3) step();
        chk("bp_idle", 32'(busy), 32'd0);

        // Event handshake: evt_ready held low
        evt_ready = 1'b0;
        push(16'd1, 8'h3C, acc);
        req_valid = 1'b0;
        step();
        step();
        chk("ack_pre", 32'(evt_valid), 32'd0);
        step();
        chk("ack_rise", 32'(evt_valid), 32'd1);
        chk("ack_data", 32'(evt_data), 32'h3C);
`ifdef EVENT_INJECT_ACK_EN
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("ack_hold%0d", i), 32'(evt_valid), 32'd1);
            chk($sformatf("ack_hdat%0d", i), 32'(evt_data), 32'h3C);
        end
        evt_ready = 1'b1;
        step();
        chk("ack_fall", 32'(evt_valid), 32'd0);
`else
        step();
        chk("noack_fall", 32'(evt_valid), 32'd0);
        chk("noack_idle", 32'(busy), 32'd0);
`endif
        evt_ready = 1'b1;
        step();

        // Flush mid-COUNT, with a request offered on the flush edge
        fire_cyc.delete();
        fire_dat.delete();
        push(16'd20, 8'h01, acc);
        push(16'd20, 8'h02, acc);
        push(16'd20, 8'h03, acc);
        req_valid = 1'b0;
        repeat (5) step();
        chk("fl_busy_before", 32'(busy), 32'd1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_delay = 16'd0;
        req_data  = 8'hEE;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl_pending", 32'(pending), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_ready", 32'(req_ready), 32'd1);
        chk("fl_valid", 32'(evt_valid), 32'd0);
        repeat (40) step();
        chk("fl_no_fire", 32'(fire_cyc.size()), 32'd0);

        // Asynchronous reset during COUNT of a D=50 event
        fire_cyc.delete();
        fire_dat.delete();
        push(16'd50, 8'h77, acc);
        req_valid = 1'b0;
        repeat (10) step();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("arst");
        repeat (3) step();
        rst = 1'b1;
        repeat (70) step();
        chk("arst_no_fire", 32'(fire_cyc.size()), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
